// File: rtl/usb_tx_pkg.sv
// Shared types and helpers for the USB TX retry FIFO.
// Holds the FSM encoding, default widths and the pointer level helper.
package usb_tx_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REWIND = 2'd2
  } state_e;

  // Callers truncate the result to the pointer width, giving modulo math.
  function automatic logic [31:0] ptr_diff(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return a - b;
  endfunction

endpackage

// File: rtl/usb_tx_fifo_ram.sv
// Simple dual-port RAM for the USB TX retry FIFO.
// One write port, one registered read port with enable and clear.
module usb_tx_fifo_ram
  import usb_tx_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic             re_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)      rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else if (re_i)  rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/usb_tx_retry_fifo.sv
// USB TX packet FIFO with speculative read, commit on ACK, rewind on retry.
// Optional stats counters: define USB_TX_RETRY_STATS_EN.
module usb_tx_retry_fifo
  import usb_tx_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEF,
  parameter int ASIZE    = ASIZE_DEF,
  parameter int AFULL_TH = 448
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] wr_data,
  output logic             full,
  output logic             afull,
  output logic [ASIZE:0]   free_cnt,
  input  logic             txact,
  input  logic             rd_en,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_valid,
  input  logic             commit,
  input  logic             abort,
  output logic             empty,
  output logic [ASIZE:0]   avail_cnt,
`ifdef USB_TX_RETRY_STATS_EN
  output logic [15:0]      retry_cnt,
  output logic [15:0]      commit_cnt,
`endif
  output logic [ASIZE:0]   pkt_len
);

  localparam int PW = ASIZE + 1;
  localparam logic [ASIZE:0] DEPTH = PW'(2**ASIZE);

  state_e         state_q, state_d;
  logic [ASIZE:0] wp_q, wp_d, rp_q, rp_d, cp_q, cp_d;
  logic [ASIZE:0] pkt_q, pkt_d;
  logic [ASIZE:0] avail_q, avail_d, free_q, free_d;
  logic           rd_valid_q, rd_valid_d;
  logic           txact_q;
  logic [ASIZE:0] used, rp_inc;
  logic           rd_acc, wr_acc, t_rise, t_fall;

  assign used   = PW'(ptr_diff(32'(wp_q), 32'(cp_q)));
  assign full   = (wp_q[ASIZE] != cp_q[ASIZE]) &&
                  (wp_q[ASIZE-1:0] == cp_q[ASIZE-1:0]);
  assign afull  = used >= PW'(AFULL_TH);
  assign empty  = rp_q == wp_q;
  assign t_rise = txact && !txact_q;
  assign t_fall = !txact && txact_q;
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = (state_q == ST_ACTIVE) && rd_en && !empty && !flush;
  assign rp_inc = rp_q + {{ASIZE{1'b0}}, rd_acc};

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q + {{ASIZE{1'b0}}, wr_acc};
    rp_d       = rp_q;
    cp_d       = cp_q;
    pkt_d      = pkt_q;
    rd_valid_d = rd_acc;
    avail_d    = used;
    free_d     = DEPTH - used;
    unique case (state_q)
      ST_IDLE: begin
        if (t_rise) begin
          rp_d    = cp_q;
          pkt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        rp_d  = rp_inc;
        pkt_d = pkt_q + {{ASIZE{1'b0}}, rd_acc};
        // Commit beats a same-cycle abort or txact drop.
        if (commit) begin
          cp_d  = rp_inc;
          pkt_d = '0;
        end else if (abort || t_fall) begin
          state_d = ST_REWIND;
        end
      end
      ST_REWIND: begin
        rp_d    = cp_q;
        pkt_d   = '0;
        state_d = txact ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d    = ST_IDLE;
      wp_d       = '0;
      rp_d       = '0;
      cp_d       = '0;
      pkt_d      = '0;
      rd_valid_d = 1'b0;
      avail_d    = '0;
      free_d     = DEPTH;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      cp_q       <= '0;
      pkt_q      <= '0;
      rd_valid_q <= 1'b0;
      avail_q    <= '0;
      free_q     <= DEPTH;
      txact_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cp_q       <= cp_d;
      pkt_q      <= pkt_d;
      rd_valid_q <= rd_valid_d;
      avail_q    <= avail_d;
      free_q     <= free_d;
      txact_q    <= txact;
    end
  end

`ifdef USB_TX_RETRY_STATS_EN
  logic [15:0] retry_q, commit_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      retry_q  <= '0;
      commit_q <= '0;
    end else if (flush) begin
      retry_q  <= '0;
      commit_q <= '0;
    end else begin
      if (state_q == ST_ACTIVE && state_d == ST_REWIND &&
          retry_q != 16'hFFFF)
        retry_q <= retry_q + 16'd1;
      if (state_q == ST_ACTIVE && commit)
        commit_q <= commit_q + 16'd1;
    end
  end

  assign retry_cnt  = retry_q;
  assign commit_cnt = commit_q;
`endif

  usb_tx_fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr_i   (flush),
    .we_i    (wr_acc),
    .waddr_i (wp_q[ASIZE-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i (rp_q[ASIZE-1:0]),
    .rdata_o (rd_data)
  );

  assign rd_valid  = rd_valid_q;
  assign pkt_len   = pkt_q;
  assign avail_cnt = avail_q;
  assign free_cnt  = free_q;

endmodule

// File: tb/tb_usb_tx_retry_fifo.sv
// Directed bench for usb_tx_retry_fifo.
// Covers reset, commit, abort rewind, full/afull, wrap and flush.
module tb_usb_tx_retry_fifo;

  logic       CLK, RSTn, flush, wr_en, txact, rd_en, commit, abort;
  logic [7:0] wr_data, rd_data;
  logic       full, afull, rd_valid, empty;
  logic [9:0] free_cnt, avail_cnt, pkt_len;
`ifdef USB_TX_RETRY_STATS_EN
  logic [15:0] retry_cnt, commit_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  usb_tx_retry_fifo dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .afull      (afull),
    .free_cnt   (free_cnt),
    .txact      (txact),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .commit     (commit),
    .abort      (abort),
    .empty      (empty),
    .avail_cnt  (avail_cnt),
`ifdef USB_TX_RETRY_STATS_EN
    .retry_cnt  (retry_cnt),
    .commit_cnt (commit_cnt),
`endif
    .pkt_len    (pkt_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] d);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check(tag, {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, d});
  endtask

  initial begin
    int errs;
    logic [7:0] e;
    RSTn = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    txact = 1'b0; rd_en = 1'b0; commit = 1'b0; abort = 1'b0;
    #12;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_free", 32'(free_cnt), 512);
    check("rst_avail", 32'(avail_cnt), 0);
    check("rst_rdv", {23'd0, rd_valid, rd_data}, 0);
    check("rst_pkt", 32'(pkt_len), 0);
    RSTn = 1'b1;
    tick();

    // 1: fill ten bytes
    for (int i = 0; i < 10; i++) wr(8'(i));
    tick();
    check("t1_avail", 32'(avail_cnt), 10);
    check("t1_free", 32'(free_cnt), 502);
    check("t1_empty", 32'(empty), 0);
    check("t1_full", 32'(full), 0);

    // 2: read four, commit together with txact drop
    txact = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) rd_chk("t2_rd", 8'(i));
    check("t2_pkt", 32'(pkt_len), 4);
    commit = 1'b1; txact = 1'b0;
    tick();
    commit = 1'b0;
    check("t2_rdv_off", 32'(rd_valid), 0);
    tick();
    check("t2_avail", 32'(avail_cnt), 6);
    check("t2_free", 32'(free_cnt), 506);
    check("t2_pkt0", 32'(pkt_len), 0);

    // 3: read three, abort, reread after one rewind cycle
    txact = 1'b1;
    tick();
    for (int i = 4; i < 7; i++) rd_chk("t3_rd", 8'(i));
    check("t3_pkt", 32'(pkt_len), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_rewind_rdv", 32'(rd_valid), 0);
    check("t3_rewind_pkt", 32'(pkt_len), 0);
    for (int i = 4; i < 7; i++) rd_chk("t3_reread", 8'(i));
`ifdef USB_TX_RETRY_STATS_EN
    check("t3_retry", 32'(retry_cnt), 1);
    check("t3_commits", 32'(commit_cnt), 1);
`endif
    commit = 1'b1; txact = 1'b0;
    tick();
    commit = 1'b0;
    tick();
    check("t3_avail", 32'(avail_cnt), 3);

    // 4: flush, then fill to full
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 512; i++) begin
      wr(8'(i));
      if (i == 446) check("t4_afull_lo", 32'(afull), 0);
      if (i == 447) check("t4_afull_hi", 32'(afull), 1);
      if (i == 510) check("t4_full_lo", 32'(full), 0);
      if (i == 511) check("t4_full_hi", 32'(full), 1);
    end
    wr(8'hEE);
    tick();
    check("t4_avail", 32'(avail_cnt), 512);
    check("t4_free", 32'(free_cnt), 0);
    check("t4_full", 32'(full), 1);

    // 5: drain 500, commit, top up 20 and read across the top
    txact = 1'b1;
    tick();
    errs  = 0;
    rd_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!(rd_valid === 1'b1 && rd_data === 8'(i))) errs++;
    end
    rd_en = 1'b0;
    check("t5_rd500", 32'(errs), 0);
    commit = 1'b1; txact = 1'b0;
    tick();
    commit = 1'b0;
    for (int k = 0; k < 20; k++) wr(8'h80 + 8'(k));
    tick();
    check("t5_avail32", 32'(avail_cnt), 32);
    check("t5_free480", 32'(free_cnt), 480);
    txact = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      e = (k < 12) ? 8'(244 + k) : 8'h80 + 8'(k - 12);
      rd_chk("t5_wrap_rd", e);
    end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("t5_avail12", 32'(avail_cnt), 12);
    check("t5_free500", 32'(free_cnt), 500);

    // 6: commit and abort together, then flush mid-transaction
    rd_chk("t6_rd88", 8'h88);
    rd_en = 1'b1; commit = 1'b1; abort = 1'b1;
    tick();
    rd_en = 1'b0; commit = 1'b0; abort = 1'b0;
    check("t6_rd89", {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, 8'h89});
    check("t6_pkt0", 32'(pkt_len), 0);
    rd_chk("t6_still_active", 8'h8A);
    check("t6_pkt1", 32'(pkt_len), 1);
    check("t6_avail", 32'(avail_cnt), 10);
    flush = 1'b1; rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    flush = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    check("t6_fl_rdv", {23'd0, rd_valid, rd_data}, 0);
    check("t6_fl_pkt", 32'(pkt_len), 0);
    check("t6_fl_avail", 32'(avail_cnt), 0);
    check("t6_fl_free", 32'(free_cnt), 512);
    check("t6_fl_empty", 32'(empty), 1);
    check("t6_fl_afull", 32'(afull), 0);
`ifdef USB_TX_RETRY_STATS_EN
    check("t6_fl_retry", 32'(retry_cnt), 0);
    check("t6_fl_commits", 32'(commit_cnt), 0);
`endif
    wr(8'h5A);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t6_idle_noread", 32'(rd_valid), 0);
    txact = 1'b0;
    tick();
    txact = 1'b1;
    tick();
    rd_chk("t6_post_flush", 8'h5A);
    check("t6_post_pkt", 32'(pkt_len), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_tx_retry_fifo.md
Name: usb_tx_retry_fifo

Overview:
Parametrised synchronous packet TX FIFO sitting between the streamer data source and the USB device-controller TX endpoint. The write side fills the FIFO freely. The read side fetches bytes speculatively during a USB IN transaction. Bytes are released only on host ACK (commit); on NAK, timeout or transaction end without ACK, the read pointer rewinds so the packet can be resent. It adds the following over the previous packet FIFO:
- explicit abort
- flush
- almost-full threshold
- committed and free level counts
- per-transaction byte count
- a small transaction state machine

Parameters:
DSIZE, 8, data width in bits
ASIZE, 9, address width; depth DEPTH = 2**ASIZE entries
AFULL_TH, 448, afull asserts when used count >= AFULL_TH (range 1..DEPTH)

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all pointers and state
wr_en  in  1  write request
wr_data  in  DSIZE  write data
full  out  1  used == DEPTH; writes ignored
afull  out  1  used >= AFULL_TH
free_cnt  out  ASIZE+1  DEPTH - used, registered
txact  in  1  USB transaction active (level)
rd_en  in  1  read request, honoured only in ACTIVE
rd_data  out  DSIZE  read data, 1-cycle latency
rd_valid  out  1  rd_data valid this cycle
commit  in  1  host ACK pulse: release bytes read in this transaction
abort  in  1  NAK/timeout pulse: rewind to last commit
empty  out  1  no unread data at speculative pointer (rp == wp)
avail_cnt  out  ASIZE+1  wp - cp (committed-unreleased bytes), registered
pkt_len  out  ASIZE+1  bytes read in current transaction

Behaviour:
Pointers and levels
- Three ASIZE+1-bit pointers with an extra wrap bit: wp (write), rp (speculative read), cp (commit base).
- used = wp - cp, modulo 2**(ASIZE+1).
- full = (wp[ASIZE] != cp[ASIZE]) && (wp[ASIZE-1:0] == cp[ASIZE-1:0]).
- empty = (rp == wp).

Reset and flush
- Reset (async) and flush (sync) zero the following: wp, rp, cp, pkt_len, rd_data, rd_valid, avail_cnt.
- Reset and flush set free_cnt = DEPTH and state = IDLE.
- flush has priority over every other input in the same cycle.

Write path
- wr_en && !full: RAM[wp] <= wr_data, wp++.
- Writes are independent of read state.

Read path
- A read is accepted when state == ACTIVE && rd_en && !empty. On acceptance: rp++, pkt_len++.
- rd_data is registered RAM[rp] and appears the cycle after acceptance with rd_valid = 1.
- Otherwise rd_valid = 0 and rd_data holds its value.

State machine (IDLE, ACTIVE, REWIND)
- IDLE: on a txact rising edge, rp <= cp, pkt_len <= 0, go to ACTIVE.
- ACTIVE, commit: cp <= rp_next, where rp_next includes a read accepted in the same cycle. pkt_len <= 0. Stay in ACTIVE.
- ACTIVE, abort or txact falling edge without commit in that cycle: go to REWIND.
- ACTIVE, commit and abort together: commit wins; the abort is ignored.
- REWIND (1 cycle): rp <= cp, pkt_len <= 0, then IDLE if txact = 0, else ACTIVE.
- commit and abort are ignored in IDLE and REWIND.

Counters
- avail_cnt and free_cnt are updated one cycle after pointer changes.
- Arithmetic is modulo 2**(ASIZE+1).
- Invariants: free_cnt never underflows; cp never passes rp; rp never passes wp.

Wrap-around
- Pointers wrap naturally through the extra bit.
- A packet straddling the RAM top is read contiguously.

Optional Feature:
USB_TX_RETRY_STATS_EN
- Defined: adds the following ports, both reset/flush to 0.
  - retry_cnt out 16: increments on every REWIND entry, saturating at 16'hFFFF.
  - commit_cnt out 16: increments on every accepted commit, wrapping.
- Undefined: neither port nor its counter exists; all other behaviour is identical.

Decomposition:
- Shared package usb_tx_pkg holds:
  - state encoding constants: ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_REWIND = 2'd2
  - default DSIZE/ASIZE values
  - function ptr_diff(a, b) for modulo level computation
- One sub-module, usb_tx_fifo_ram: simple dual-port RAM with a registered read port, one write port and one read port, inferable as block RAM. Pointer logic and the FSM stay in the top.

Test Plan:
1. Reset, write 10 bytes 0x00..0x09 -> avail_cnt = 10, free_cnt = 502, empty = 0, full = 0.
2. txact = 1, read 4 bytes, commit, txact = 0 -> rd_data sequence 00,01,02,03 each with rd_valid the cycle after rd_en; avail_cnt = 6, free_cnt = 506.
3. txact = 1, read 3 bytes, abort -> REWIND for 1 cycle; next transaction rereads 04,05,06; retry_cnt = 1 with USB_TX_RETRY_STATS_EN.
4. Write 512 bytes with no commit -> full = 1 at the 512th; the 513th write is ignored (wp unchanged); afull rises when used reaches 448.
5. Wrap: commit 500 bytes, write 20 more, read 20 across the top -> data contiguous, cp wraps to 8 with bit ASIZE toggled, avail_cnt correct.
6. Same-cycle commit + abort, then flush mid-ACTIVE -> commit honoured; flush returns state IDLE, all counts 0, free_cnt = 512.
